scanout_fetch_ctrl: RTL and testbench
=====================================

# scanout_fetch_ctrl

Scanout controller between the single-port framebuffer RAM and the display timing generator. At the start of every scanline it prefetches the next visible line from the framebuffer into one bank of a ping-pong line buffer. Meanwhile the display side reads the other bank at the current pixel position. It also arbitrates the framebuffer port between this prefetch (fixed highest priority) and one valid/ready pixel writer.

## Interface
- PIX_W, 16, bits per pixel
- H_ACTIVE, 240, visible pixels per line
- V_ACTIVE, 320, visible lines per frame
- H_BITS, 9, width of pos_h from timing generator
- V_BITS, 9, width of pos_v; 2^V_BITS ≥ V_ACTIVE + vsync + back-porch lines
- FB_ADDR_W, $clog2(H_ACTIVE*V_ACTIVE), framebuffer word address width
- clk  in  1  system clock (single clock domain)
- rst  in  1  asynchronous, active-high reset
- hsync  in  1  timing-gen hsync, low during sync pulse
- pos_h  in  H_BITS  current display column (timing gen)
- pos_v  in  V_BITS  current display row, wraps negative in blanking
- active  in  1  timing gen display-region flag
- wr_valid  in  1  writer request
- wr_ready  out  1  writer grant
- wr_addr  in  FB_ADDR_W  writer pixel address
- wr_data  in  PIX_W  writer pixel
- fb_addr  out  FB_ADDR_W  framebuffer address
- fb_rd_en  out  1  framebuffer read strobe
- fb_wr_en  out  1  framebuffer write strobe
- fb_wdata  out  PIX_W  framebuffer write data
- fb_rdata  in  PIX_W  framebuffer read data, valid 1 clk after fb_rd_en
- pix_out  out  PIX_W  pixel to panel
- overrun  out  1  sticky: a fetch did not finish within its line
- overrun_clr  in  1  synchronous clear of overrun

## Operation
- Line start: falling edge of hsync (registered hsync_q=1, hsync=0), one clk pulse.
- On line start: target = pos_v + 1 (V_BITS wrap). If target < V_ACTIVE: latch target, base = target*H_ACTIVE, bank = target[0], col = 0, enter FETCH. Otherwise no fetch.
- FSM IDLE / FETCH / DRAIN:
  - IDLE: port given to writer. wr_ready = 1 unless a line start occurs this cycle. fb_wr_en = wr_valid & wr_ready, fb_addr = wr_addr, fb_wdata = wr_data.
  - FETCH: fb_rd_en=1, fb_addr = base+col, col++ each clk. After col = H_ACTIVE-1 is issued, go to DRAIN.
  - DRAIN: one clk. Last fb_rdata is written, then go to IDLE.
- Read data of col c is written to linebuf[bank][c] the clk after issue (registered col/valid pipeline).
- Display side: rd_bank = pos_v[0]. pix_out <= active ? linebuf[rd_bank][pos_h] : 0. Fetch bank and display bank always differ.
- Line start while in FETCH/DRAIN: abort the current fetch, discard its in-flight read, set overrun, start the new fetch the same clk.
- overrun_clr and a new overrun in the same clk: set wins.
- Reset mid-fetch: state IDLE immediately. Line buffer contents are undefined until refetched.

## Timing
- Reset values: wr_ready 0, fb_rd_en 0, fb_wr_en 0, fb_addr 0, fb_wdata 0, pix_out 0, overrun 0. hsync_q resets to 1.
- Port outputs are combinational from state and registers. Writer data transfers in the clk where wr_valid & wr_ready.
- Fetch takes H_ACTIVE+1 clks from the line-start clk to return to IDLE. Writer stall is at most H_ACTIVE+2 clks per line.
- Required: H_ACTIVE+2 < line period in clk cycles. Otherwise overrun.
- pix_out latency: 1 clk after pos_h/active.
- Line 0 is fetched during the last back-porch line (pos_v = all-ones). Back porch must be ≥ 1 line.

## Structure
- Shared package scanout_pkg: fetch state enum (IDLE, FETCH, DRAIN) and the default PIX_W/H_ACTIVE/V_ACTIVE constants. The timing generator uses the same constants.
- Sub-module line_buffer_2bank: 2×H_ACTIVE×PIX_W simple dual-port RAM. One write port (bank, col, data); one registered read port (bank, col).
- Top: edge detect, FSM, address generation, arbitration, overrun flag.

## Test plan
- Reset asserted mid-FETCH (col=100) → next clk: fb_rd_en=0, pix_out=0, wr_ready=1; overrun stays 0.
- pos_v=0x1FF at hsync fall → fetch line 0. fb_addr runs 0..239 on 240 consecutive clks with fb_rd_en=1. Back in IDLE at clk 241.
- pos_v=4 at hsync fall → fetch line 5 into bank 1, fb_addr 1200..1439. Display reads bank 0 throughout.
- pos_v=319 at hsync fall → target 320 ≥ V_ACTIVE, so no fetch and wr_ready stays 1.
- Writer holds wr_valid=1 (addr 7, data 0xABCD) across a line start → wr_ready=0 for 242 clks. The write then completes once, with fb_wr_en=1, fb_addr=7, fb_wdata=0xABCD.
- Second hsync fall injected 50 clks into a fetch → overrun=1, new fetch restarts at col 0. overrun_clr=1 → overrun=0 the next clk.

Source files
------------

// File: rtl/scanout_pkg.sv
// Shared scanout definitions: fetch FSM states and default panel geometry,
// also used by the display timing generator.
package scanout_pkg;

  localparam int DEFAULT_PIX_W    = 16;
  localparam int DEFAULT_H_ACTIVE = 240;
  localparam int DEFAULT_V_ACTIVE = 320;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  // Framebuffer word address of the first pixel of a line.
  function automatic int unsigned line_base(input int unsigned line,
                                            input int unsigned width);
    return line * width;
  endfunction

endpackage

// File: rtl/line_buffer_2bank.sv
// Ping-pong line buffer: two banks of DEPTH pixels, one write port and
// one registered read port.
module line_buffer_2bank
  import scanout_pkg::*;
#(
  parameter int PIX_W = DEFAULT_PIX_W,
  parameter int DEPTH = DEFAULT_H_ACTIVE,
  parameter int COL_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic             wr_bank,
  input  logic [COL_W-1:0] wr_col,
  input  logic [PIX_W-1:0] wr_data,
  input  logic             rd_en,
  input  logic             rd_bank,
  input  logic [COL_W-1:0] rd_col,
  output logic [PIX_W-1:0] rd_data
);

  logic [PIX_W-1:0] mem [2][DEPTH];

  // NOTE: the storage array is deliberately left without reset so it maps
  // onto block RAM; only the read register below is reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_bank][wr_col] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_bank][rd_col];
    end
  end

endmodule

// File: rtl/scanout_fetch_ctrl.sv
// Scanout controller: prefetches the next visible line into a ping-pong line
// buffer at each line start and lends the framebuffer port to a pixel writer.
module scanout_fetch_ctrl
  import scanout_pkg::*;
#(
  parameter int PIX_W     = DEFAULT_PIX_W,
  parameter int H_ACTIVE  = DEFAULT_H_ACTIVE,
  parameter int V_ACTIVE  = DEFAULT_V_ACTIVE,
  parameter int H_BITS    = 9,
  parameter int V_BITS    = 9,
  parameter int FB_ADDR_W = $clog2(H_ACTIVE * V_ACTIVE)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 hsync,
  input  logic [H_BITS-1:0]    pos_h,
  input  logic [V_BITS-1:0]    pos_v,
  input  logic                 active,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [FB_ADDR_W-1:0] wr_addr,
  input  logic [PIX_W-1:0]     wr_data,
  output logic [FB_ADDR_W-1:0] fb_addr,
  output logic                 fb_rd_en,
  output logic                 fb_wr_en,
  output logic [PIX_W-1:0]     fb_wdata,
  input  logic [PIX_W-1:0]     fb_rdata,
  output logic [PIX_W-1:0]     pix_out,
  output logic                 overrun,
  input  logic                 overrun_clr
);

  localparam int COL_W = $clog2(H_ACTIVE);

  fetch_state_e         state;
  logic                 hsync_q;
  logic [FB_ADDR_W-1:0] base_q;
  logic [COL_W-1:0]     col_q;
  logic                 bank_q;

  logic                 rd_valid_q;
  logic [COL_W-1:0]     wr_col_q;
  logic                 wr_bank_q;
  logic                 disp_valid_q;

  logic                 line_start;
  logic                 fetch_go;
  logic [V_BITS-1:0]    target;
  logic                 disp_rd_en;
  logic [PIX_W-1:0]     buf_rdata;

  assign line_start = hsync_q & ~hsync;
  assign target     = pos_v + V_BITS'(1);
  assign fetch_go   = line_start && (target < V_BITS'(V_ACTIVE));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) hsync_q <= 1'b1;
    else     hsync_q <= hsync;
  end

  // NOTE: every register here uses non-blocking assignment so that all state
  // updates see the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      base_q <= '0;
      col_q  <= '0;
      bank_q <= 1'b0;
    end else if (fetch_go) begin
      // A line start always wins, including over a fetch still in progress.
      state  <= FETCH;
      base_q <= FB_ADDR_W'(line_base(32'(target), H_ACTIVE));
      col_q  <= '0;
      bank_q <= target[0];
    end else if (line_start && state != IDLE) begin
      state <= IDLE;
    end else begin
      case (state)
        FETCH: begin
          if (col_q == COL_W'(H_ACTIVE - 1)) state <= DRAIN;
          else                               col_q <= col_q + 1'b1;
        end
        DRAIN:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: each output gets a default before the case so no latch is inferred.
  always_comb begin
    wr_ready = 1'b0;
    fb_rd_en = 1'b0;
    fb_addr  = '0;
    fb_wdata = '0;
    if (!rst) begin
      case (state)
        IDLE: begin
          wr_ready = ~fetch_go;
          fb_addr  = wr_addr;
          fb_wdata = wr_data;
        end
        FETCH: begin
          fb_rd_en = ~line_start;
          fb_addr  = base_q + FB_ADDR_W'(col_q);
        end
        default: ;
      endcase
    end
  end

  assign fb_wr_en = wr_valid & wr_ready;

  // Read data lands one clk after issue; tag it with the column and bank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      wr_col_q   <= '0;
      wr_bank_q  <= 1'b0;
    end else begin
      rd_valid_q <= fb_rd_en;
      wr_col_q   <= col_q;
      wr_bank_q  <= bank_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             overrun <= 1'b0;
    else if (line_start && state != IDLE) overrun <= 1'b1;
    else if (overrun_clr)                overrun <= 1'b0;
  end

  // Display side reads the bank of the current row; the fetch targets the next.
  assign disp_rd_en = active && (pos_h < H_BITS'(H_ACTIVE));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) disp_valid_q <= 1'b0;
    else     disp_valid_q <= disp_rd_en;
  end

  line_buffer_2bank #(
    .PIX_W (PIX_W),
    .DEPTH (H_ACTIVE),
    .COL_W (COL_W)
  ) u_line_buffer (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (rd_valid_q & ~line_start),
    .wr_bank (wr_bank_q),
    .wr_col  (wr_col_q),
    .wr_data (fb_rdata),
    .rd_en   (disp_rd_en),
    .rd_bank (pos_v[0]),
    .rd_col  (COL_W'(pos_h)),
    .rd_data (buf_rdata)
  );

  assign pix_out = disp_valid_q ? buf_rdata : '0;

endmodule

// File: tb/tb_scanout_fetch_ctrl.sv
// Directed bench for scanout_fetch_ctrl with a behavioural framebuffer model.
module tb_scanout_fetch_ctrl;

  localparam int PIX_W     = 16;
  localparam int H_ACTIVE  = 240;
  localparam int V_ACTIVE  = 320;
  localparam int H_BITS    = 9;
  localparam int V_BITS    = 9;
  localparam int FB_ADDR_W = 17;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 hsync;
  logic [H_BITS-1:0]    pos_h;
  logic [V_BITS-1:0]    pos_v;
  logic                 active;
  logic                 wr_valid;
  logic                 wr_ready;
  logic [FB_ADDR_W-1:0] wr_addr;
  logic [PIX_W-1:0]     wr_data;
  logic [FB_ADDR_W-1:0] fb_addr;
  logic                 fb_rd_en;
  logic                 fb_wr_en;
  logic [PIX_W-1:0]     fb_wdata;
  logic [PIX_W-1:0]     fb_rdata = '0;
  logic [PIX_W-1:0]     pix_out;
  logic                 overrun;
  logic                 overrun_clr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  scanout_fetch_ctrl #(
    .PIX_W(PIX_W), .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE),
    .H_BITS(H_BITS), .V_BITS(V_BITS), .FB_ADDR_W(FB_ADDR_W)
  ) dut (
    .clk(clk), .rst(rst), .hsync(hsync), .pos_h(pos_h), .pos_v(pos_v),
    .active(active), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .fb_addr(fb_addr),
    .fb_rd_en(fb_rd_en), .fb_wr_en(fb_wr_en), .fb_wdata(fb_wdata),
    .fb_rdata(fb_rdata), .pix_out(pix_out), .overrun(overrun),
    .overrun_clr(overrun_clr)
  );

  // Framebuffer contents are a fixed function of the address.
  function automatic logic [PIX_W-1:0] pix_fn(input int unsigned a);
    return PIX_W'(a) ^ 16'h5A5A;
  endfunction

  always @(posedge clk) begin
    if (fb_rd_en) fb_rdata <= pix_fn(32'(fb_addr));
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Caller has just driven the hsync fall; walks the H_ACTIVE fetch cycles and DRAIN.
  task automatic fetch_line(input int line, input bit disp, input int disp_line);
    for (int c = 0; c < H_ACTIVE; c++) begin
      tick();
      hsync = 1'b1;
      if (disp) begin
        pos_h  = H_BITS'(c);
        active = 1'b1;
      end
      #1;
      check($sformatf("l%0d_rd_en_c%0d", line, c), fb_rd_en, 1);
      check($sformatf("l%0d_addr_c%0d", line, c), fb_addr, line * H_ACTIVE + c);
      if (disp && c > 0)
        check($sformatf("l%0d_disp_c%0d", line, c), pix_out,
              pix_fn(disp_line * H_ACTIVE + c - 1));
    end
    tick();
    active = 1'b0;
    #1;
    check($sformatf("l%0d_drain_rd_en", line), fb_rd_en, 0);
    check($sformatf("l%0d_drain_wr_ready", line), wr_ready, 0);
    tick();
    #1;
    check($sformatf("l%0d_idle_wr_ready", line), wr_ready, 1);
    check($sformatf("l%0d_idle_rd_en", line), fb_rd_en, 0);
  endtask

  task automatic disp_check(input string tag, input int row, input int h,
                            input logic [PIX_W-1:0] exp);
    tick();
    pos_v  = V_BITS'(row);
    pos_h  = H_BITS'(h);
    active = 1'b1;
    tick();
    active = 1'b0;
    #1;
    check(tag, pix_out, exp);
  endtask

  initial begin
    int stall;
    int wr_seen;
    bit done;

    rst = 1'b1; hsync = 1'b1; pos_h = '0; pos_v = '0; active = 1'b0;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0; overrun_clr = 1'b0;

    tick(); #1;
    check("rst_wr_ready", wr_ready, 0);
    check("rst_fb_rd_en", fb_rd_en, 0);
    check("rst_fb_wr_en", fb_wr_en, 0);
    check("rst_fb_addr", fb_addr, 0);
    check("rst_fb_wdata", fb_wdata, 0);
    check("rst_pix_out", pix_out, 0);
    check("rst_overrun", overrun, 0);

    tick(); rst = 1'b0; #1;
    check("idle_wr_ready", wr_ready, 1);

    // Line 0 fetched during the last back-porch line.
    tick(); pos_v = 9'h1FF; hsync = 1'b0; #1;
    check("ls0_wr_ready", wr_ready, 0);
    check("ls0_rd_en", fb_rd_en, 0);
    fetch_line(0, 1'b0, 0);

    disp_check("disp_l0_h0", 0, 0, pix_fn(0));
    disp_check("disp_l0_h119", 0, 119, pix_fn(119));
    disp_check("disp_l0_h239", 0, 239, pix_fn(239));
    tick(); pos_h = 9'd10; active = 1'b0; tick(); #1;
    check("disp_inactive", pix_out, 0);

    // Line 5 into bank 1 while the display keeps reading bank 0 (line 0 data).
    tick(); pos_v = 9'd4; hsync = 1'b0; #1;
    check("ls5_wr_ready", wr_ready, 0);
    fetch_line(5, 1'b1, 0);
    disp_check("disp_l5_h0", 5, 0, pix_fn(1200));
    disp_check("disp_l5_h239", 5, 239, pix_fn(1439));

    // Last visible line: next target is off-screen, no fetch.
    tick(); pos_v = 9'd319; hsync = 1'b0; #1;
    check("ls320_wr_ready", wr_ready, 1);
    tick(); hsync = 1'b1; #1;
    check("ls320_rd_en", fb_rd_en, 0);
    check("ls320_wr_ready_after", wr_ready, 1);

    // Writer held across a line start.
    tick(); pos_v = 9'd1; hsync = 1'b0;
    wr_valid = 1'b1; wr_addr = 17'd7; wr_data = 16'hABCD; #1;
    check("wr_ls_fb_wr_en", fb_wr_en, 0);
    stall = 1; wr_seen = 0; done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      tick(); hsync = 1'b1; #1;
      if (wr_ready) done = 1'b1;
      else begin
        stall++;
        if (fb_wr_en) wr_seen++;
      end
    end
    check("wr_stall_cycles", stall, 242);
    check("wr_during_stall", wr_seen, 0);
    check("wr_fb_wr_en", fb_wr_en, 1);
    check("wr_fb_addr", fb_addr, 7);
    check("wr_fb_wdata", fb_wdata, 16'hABCD);
    tick(); wr_valid = 1'b0; #1;
    check("wr_done_fb_wr_en", fb_wr_en, 0);

    // Overrun: second line start 50 clks into the fetch of line 10.
    tick(); pos_v = 9'd9; hsync = 1'b0; #1;
    for (int i = 0; i < 50; i++) begin
      tick(); hsync = 1'b1; #1;
    end
    check("ovr_pre_addr", fb_addr, 10 * H_ACTIVE + 49);
    tick(); pos_v = 9'd10; hsync = 1'b0; #1;
    check("ovr_ls_rd_en", fb_rd_en, 0);
    check("ovr_ls_overrun", overrun, 0);
    tick(); hsync = 1'b1; #1;
    check("ovr_set", overrun, 1);
    check("ovr_restart_rd_en", fb_rd_en, 1);
    check("ovr_restart_addr", fb_addr, 11 * H_ACTIVE);
    tick(); overrun_clr = 1'b1; #1;
    check("ovr_col1_addr", fb_addr, 11 * H_ACTIVE + 1);
    check("ovr_before_clr", overrun, 1);
    tick(); overrun_clr = 1'b0; #1;
    check("ovr_cleared", overrun, 0);
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      tick(); #1;
      if (wr_ready) done = 1'b1;
    end
    check("ovr_fetch_finished", done, 1);
    // Bank 0: cols 0..48 from aborted line 10, col 49 discarded (still line 2).
    disp_check("ovr_bank0_h48", 0, 48, pix_fn(10 * H_ACTIVE + 48));
    disp_check("ovr_bank0_h49", 0, 49, pix_fn(2 * H_ACTIVE + 49));
    disp_check("ovr_bank1_h100", 1, 100, pix_fn(11 * H_ACTIVE + 100));

    // Reset asserted mid-fetch at column 100 of line 21.
    tick(); pos_v = 9'd20; hsync = 1'b0; #1;
    for (int c = 0; c <= 100; c++) begin
      tick(); hsync = 1'b1; pos_h = 9'd5; active = 1'b1; #1;
    end
    check("rst_mid_addr", fb_addr, 21 * H_ACTIVE + 100);
    check("rst_mid_pix", pix_out, pix_fn(10 * H_ACTIVE + 5));
    tick(); rst = 1'b1; #1;
    check("rst_mid_rd_en_async", fb_rd_en, 0);
    tick(); rst = 1'b0; #1;
    check("rst_after_rd_en", fb_rd_en, 0);
    check("rst_after_pix", pix_out, 0);
    check("rst_after_wr_ready", wr_ready, 1);
    check("rst_after_overrun", overrun, 0);
    tick(); active = 1'b0; #1;
    check("rst_after_idle_rd_en", fb_rd_en, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
